shift_and_subtract_binary_divider: RTL and testbench
====================================================

Name: shift_and_subtract_binary_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse of the team's shift-and-add multiplier.
- Takes a DW-bit dividend and a VW-bit divisor and resolves one quotient bit per clock, MSB first.
- Returns quotient and remainder with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath. With default widths, a 16-bit product divided by one 8-bit factor returns the other factor with zero remainder.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width.
- CW, 5, iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  DW  dividend, captured on the accepted-start edge.
- B  input  VW  divisor, captured on the accepted-start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; Q/R/dbz are valid from this cycle on.
- Q  output  DW  quotient.
- R  output  VW  remainder.
- dbz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; busy=0, done=0, Q=0, R=0, dbz=0; counter and working registers cleared. Reset mid-RUN aborts the operation with no done pulse.
- Registers:
  - Working dividend/quotient shift register, DW bits.
  - Partial remainder, VW+1 bits, so the trial subtract never overflows.
  - Captured divisor, VW bits.
  - Counter, CW bits.
- IDLE:
  - start=1 with B!=0: capture A and B, clear the partial remainder, counter=0, go to RUN.
  - start=1 with B==0: go to DONE with Q=all ones, R=0, dbz=1.
  - start=0: stay in IDLE; outputs hold.
- RUN, one iteration per edge:
  - Shift the remainder left, bringing in the dividend MSB: pr = {pr[VW-1:0], w[DW-1]}.
  - Shift the working register left.
  - If pr >= divisor: pr = pr - divisor and shift 1 into the working LSB; else shift 0 in.
  - Counter increments. On the edge where counter==DW-1 (the DW-th iteration), load Q from the final working register, R from the final pr[VW-1:0], set dbz=0, and go to DONE.
- DONE (exactly one cycle): done=1, busy=0.
  - start=1: accept as in IDLE (back-to-back operation, no bubble).
  - Else return to IDLE.
- Latency:
  - With start sampled at edge 0, busy is high for cycles 1..DW and done is high in cycle DW+1 (17 cycles with defaults).
  - A divide-by-zero start gives done in cycle 1.
- start while busy is ignored; operands are not re-captured.
- A and B may change freely after the accepted-start edge.
- Q, R and dbz hold from done until the next completed operation. They are not cleared on the next start.
- Invariants: A == Q*B + R, R < B for B!=0, and all arithmetic is unsigned.

Decomposition:
- Shared package (arith_pkg): state enum {IDLE, RUN, DONE} and default width constants DW_DEF=16, VW_DEF=8. The multiplier may reuse these constants.
- One combinational sub-module, div_step: takes pr_in (VW+1), bit_in and divisor (VW); returns pr_out (VW+1) and q_bit from the trial subtract.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset, then A=200, B=7, start one cycle -> busy in cycles 1..16, done in cycle 17 only; Q=28, R=4, dbz=0.
- A=65535, B=255 -> Q=257, R=0. Then A=5, B=9 -> Q=0, R=5. Then A=0, B=1 -> Q=0, R=0.
- A=1234, B=0 -> done in cycle 1; Q=16'hFFFF, R=0, dbz=1. A following valid divide clears dbz to 0.
- start=1 with A=100, B=3, then start pulses with A=9, B=9 at cycles 5 and 10 -> ignored; result Q=33, R=1.
- start held high continuously with A=50, B=6 -> back-to-back results (Q=8, R=2) with done in cycles 17, 34, 51. No idle gap.
- rst=0 at cycle 8 of a run -> next cycle busy=0, done=0, Q=R=dbz=0; no done pulse appears afterwards. A fresh 40/8 start gives Q=5, R=0.
- Randomized: 1000 random A, B (B!=0) -> Q*B+R==A and R<B for every result.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath package: FSM state encoding and default operand widths
// used by the shift-and-add multiplier and the shift-and-subtract divider.
package arith_pkg;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned VW_DEF = 8;
   localparam int unsigned CW_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_and_subtract_binary_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
   parameter int unsigned VW = 8
) (
   input  logic [VW:0]   pr_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   pr_out,
   output logic          q_bit
);

   logic [VW+1:0] shifted;
   logic [VW+1:0] dvs_ext;

   // One extra guard bit keeps the compare exact even if pr_in's MSB were ever set
   assign shifted = {pr_in, bit_in};
   assign dvs_ext = (VW+2)'(divisor);
   assign q_bit   = (shifted >= dvs_ext);
   assign pr_out  = q_bit ? (VW+1)'(shifted - dvs_ext) : (VW+1)'(shifted);

endmodule

// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first,
// with a start/busy/done handshake and a divide-by-zero flag.
module shift_and_subtract_binary_divider
   import arith_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned VW = VW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] A,
   input  logic [VW-1:0] B,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          dbz
);

   state_t        state, state_nxt;
   logic [DW-1:0] w, w_nxt;
   logic [VW:0]   pr, pr_nxt;
   logic [VW-1:0] dvs, dvs_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [DW-1:0] q_nxt;
   logic [VW-1:0] r_nxt;
   logic          dbz_nxt;

   logic [VW:0]   pr_step;
   logic          q_bit;
   logic          accept;
   logic          last;

   div_step #(.VW(VW)) u_step (
      .pr_in   (pr),
      .bit_in  (w[DW-1]),
      .divisor (dvs),
      .pr_out  (pr_step),
      .q_bit   (q_bit)
   );

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (cnt == CW'(DW-1));

   // State and all registered outputs/datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         w     <= '0;
         pr    <= '0;
         dvs   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Q     <= '0;
         R     <= '0;
         dbz   <= 1'b0;
      end else begin
         state <= state_nxt;
         w     <= w_nxt;
         pr    <= pr_nxt;
         dvs   <= dvs_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
         Q     <= q_nxt;
         R     <= r_nxt;
         dbz   <= dbz_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = (B == '0) ? DONE : RUN;
            else        state_nxt = IDLE;
         end
         RUN:     state_nxt = last ? DONE : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and result updates
   always_comb begin
      w_nxt   = w;
      pr_nxt  = pr;
      dvs_nxt = dvs;
      cnt_nxt = cnt;
      q_nxt   = Q;
      r_nxt   = R;
      dbz_nxt = dbz;
      if (accept) begin
         if (B != '0) begin
            w_nxt   = A;
            dvs_nxt = B;
            pr_nxt  = '0;
            cnt_nxt = '0;
         end else begin
            q_nxt   = '1;
            r_nxt   = '0;
            dbz_nxt = 1'b1;
         end
      end else if (state == RUN) begin
         w_nxt   = {w[DW-2:0], q_bit};
         pr_nxt  = pr_step;
         cnt_nxt = cnt + CW'(1);
         if (last) begin
            q_nxt   = {w[DW-2:0], q_bit};
            r_nxt   = pr_step[VW-1:0];
            dbz_nxt = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Directed and randomized checks of the restoring divider against a division
// scoreboard, including latency, handshake, divide-by-zero and reset abort.
module tb_shift_and_subtract_binary_divider;

   localparam int unsigned DW = 16;
   localparam int unsigned VW = 8;

   typedef struct {
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dbz;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] A;
   logic [VW-1:0] B;
   logic          busy, done, dbz;
   logic [DW-1:0] Q;
   logic [VW-1:0] R;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   shift_and_subtract_binary_divider #(.DW(DW), .VW(VW), .CW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
      exp_t e;
      e.a   = a;
      e.b   = b;
      e.dbz = (b == '0);
      e.q   = e.dbz ? '1 : DW'(a / b);
      e.r   = e.dbz ? '0 : VW'(a % b);
      sb.push_back(e);
      A     = a;
      B     = b;
      start = 1'b1;
   endtask

   task automatic compare_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_q"},   32'(Q),   32'(e.q));
         chk({tag, "_r"},   32'(R),   32'(e.r));
         chk({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
         if (!e.dbz) begin
            chk({tag, "_inv"},  32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
            chk({tag, "_rltb"}, 32'(R < e.b), 32'd1);
         end
      end
   endtask

   // Cycle-exact run: busy in cycles 1..DW, done only in cycle DW+1 (or cycle 1 for B==0)
   task automatic exact_run(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
      int lat;
      logic [DW-1:0] qexp;
      qexp = (b == '0) ? '1 : DW'(a / b);
      lat  = (b == '0) ? 1 : DW + 1;
      start_op(a, b);
      step();
      start = 1'b0;
      for (int c = 1; c < lat; c++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         step();
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      compare_result(tag);
      step();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_q_hold"}, 32'(Q), 32'(qexp));
   endtask

   task automatic wait_result(input string tag, input int max_cyc);
      int n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      if (done !== 1'b1) chk({tag, "_timeout"}, 32'(done), 32'd1);
      else               compare_result(tag);
   endtask

   initial begin
      int   nd;
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;

      rst   = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q",    32'(Q),    32'd0);
      chk("rst_r",    32'(R),    32'd0);
      chk("rst_dbz",  32'(dbz),  32'd0);
      rst = 1'b1;
      step();

      exact_run("d200_7", 16'd200, 8'd7);
      exact_run("dmax", 16'd65535, 8'd255);
      exact_run("d5_9", 16'd5, 8'd9);
      exact_run("d0_1", 16'd0, 8'd1);
      exact_run("dbz", 16'd1234, 8'd0);
      exact_run("dbz_clear", 16'd77, 8'd10);

      // Starts while busy must be ignored and operands not re-captured
      start_op(16'd100, 8'd3);
      step();
      for (int c = 1; c <= DW; c++) begin
         if (c == 5 || c == 10) begin
            A = 16'd9; B = 8'd9; start = 1'b1;
         end else begin
            start = 1'b0; A = 16'hBEEF; B = 8'd0;
         end
         chk("ign_busy", 32'(busy), 32'd1);
         step();
      end
      chk("ign_done", 32'(done), 32'd1);
      compare_result("ign");
      for (int c = 0; c < 5; c++) step();
      chk("ign_idle_done", 32'(done), 32'd0);
      chk("ign_idle_busy", 32'(busy), 32'd0);

      // start held high: back-to-back results with done in cycles 17, 34, 51
      for (int k = 0; k < 3; k++) start_op(16'd50, 8'd6);
      step();
      for (int c = 1; c <= 3 * (DW + 1); c++) begin
         if (c % (DW + 1) == 0) begin
            chk("b2b_done", 32'(done), 32'd1);
            compare_result("b2b");
            if (c == 3 * (DW + 1)) start = 1'b0;
         end else begin
            chk("b2b_busy", 32'(busy), 32'd1);
         end
         step();
      end
      chk("b2b_stop", 32'(busy), 32'd0);

      // Reset mid-run aborts without a done pulse
      A = 16'd1000; B = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 8; c++) step();
      rst = 1'b0;
      step();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q",    32'(Q),    32'd0);
      chk("abort_r",    32'(R),    32'd0);
      chk("abort_dbz",  32'(dbz),  32'd0);
      rst = 1'b1;
      nd = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (done === 1'b1) nd++;
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      exact_run("d40_8", 16'd40, 8'd8);

      // Randomized operands
      for (int i = 0; i < 1000; i++) begin
         ra = DW'($urandom);
         rb = VW'($urandom_range(255, 1));
         start_op(ra, rb);
         step();
         start = 1'b0;
         wait_result("rnd", 40);
         step();
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
